char_mem_dp_fill: RTL and testbench
===================================

CHAR_MEM_DP_FILL -- requirements
Module: char_mem_dp_fill

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width per port (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 13, word address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter OUT_REG, default 0, 1 adds an output register stage on both ports.
REQ-004 SHALL have ports:
  clk  in  1  sole clock
  reset  in  1  synchronous, active-high reset
  reset_req  in  1  memory clock-enable inhibit; high freezes array and engine
  s1_address  in  ADDR_W  port 1 word address
  s1_chipselect  in  1  port 1 select
  s1_write  in  1  port 1 write strobe
  s1_byteenable  in  DATA_W/8  port 1 byte lanes
  s1_writedata  in  DATA_W  port 1 write data
  s1_readdata  out  DATA_W  port 1 read data
  s1_readdatavalid  out  1  port 1 read data qualifier
  s2_address  in  ADDR_W  port 2 word address
  s2_chipselect  in  1  port 2 select
  s2_write  in  1  port 2 write strobe
  s2_byteenable  in  DATA_W/8  port 2 byte lanes
  s2_writedata  in  DATA_W  port 2 write data
  s2_readdata  out  DATA_W  port 2 read data
  s2_readdatavalid  out  1  port 2 read data qualifier
  s2_waitrequest  out  1  port 2 stall while fill engine owns port 2
  fill_start  in  1  one-cycle fill request
  fill_base  in  ADDR_W  first fill address
  fill_len  in  ADDR_W+1  words to fill (0..2^ADDR_W)
  fill_value  in  DATA_W  fill word
  fill_busy  out  1  engine active
  fill_done  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement a 2^ADDR_W x DATA_W array, true dual-port, both ports on clk, every operation gated by ~reset_req.
REQ-006 SHALL perform a port write when chipselect & write (and, port 2, ~s2_waitrequest); only lanes with byteenable=1 update.
REQ-007 SHALL perform a port read when chipselect & ~write; readdata valid 1+OUT_REG cycles later, marked by a one-cycle readdatavalid pulse.
REQ-008 SHALL hold readdata between reads; readdatavalid low when no read completes.
REQ-009 Mixed-port read-during-write: reader SHALL return old data.
REQ-010 Same-port read-during-write: not applicable (write cycle issues no read).
REQ-011 Simultaneous writes to same address, both ports: port 1 data SHALL win for overlapping enabled lanes; port 2 lanes not written by port 1 SHALL update.
REQ-012 Fill FSM states: IDLE, FILL, DONE.
REQ-013 IDLE -> FILL on fill_start with fill_len>0; capture base, len, value; fill_busy=1 from next cycle.
REQ-014 IDLE -> DONE on fill_start with fill_len=0; no array write.
REQ-015 FILL: one full-width write per enabled cycle at base+i, address wrapping modulo 2^ADDR_W; after len writes -> DONE.
REQ-016 DONE: fill_done=1 for exactly one cycle, fill_busy=0, then -> IDLE.
REQ-017 fill_start while FILL or DONE SHALL be ignored.
REQ-018 During FILL, s2_waitrequest=1; host port 2 requests stall, no port 2 read/write occurs; port 1 unaffected and wins collisions with the engine.
REQ-019 reset_req=1 SHALL freeze FSM, counters, pipeline registers and outputs; operation resumes unchanged when it falls.
REQ-020 fill_len counter SHALL be ADDR_W+1 bits so a full-depth fill (2^ADDR_W) completes exactly once.

Reset
REQ-021 On reset: FSM=IDLE, fill_busy=0, fill_done=0, s2_waitrequest=0, readdatavalid=0 both ports, readdata=0 both ports.
REQ-022 Reset mid-fill SHALL abort at once; words already written remain; no fill_done pulse.
REQ-023 Reset SHALL NOT clear array contents; reset overrides reset_req.

Verification
REQ-024 Write 0xA5 @0x0010 via s1, read @0x0010 via s2 -> s2_readdata=0xA5, readdatavalid at cycle +1 (OUT_REG=0), +2 (OUT_REG=1).
REQ-025 Same cycle: s1 writes 0x11 @0x0100, s2 reads @0x0100 holding 0x22 -> s2 returns 0x22, later read returns 0x11.
REQ-026 fill_base=0x1FFE, fill_len=4, fill_value=0x20 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001 =0x20, 0x0002 unchanged, fill_busy 4 cycles, one fill_done pulse.
REQ-027 s2 write during fill -> s2_waitrequest held high until fill_busy falls, write then lands; concurrent s1 write to a filled address keeps s1 value.
REQ-028 reset_req high 3 cycles mid-fill -> fill_busy stretched by 3 cycles, all words written once; reset mid-fill -> fill_busy=0 next cycle, no fill_done.
REQ-029 fill_len=0 -> fill_done pulse 1 cycle after fill_start, no writes; fill_len=8192 -> whole array = fill_value.

Source files
------------

// File: rtl/char_mem_dp_fill.sv
`default_nettype none
// ============================================================================
// Module      : char_mem_dp_fill
// Description : True dual-port character memory with byte-lane writes and a
//               hardware fill engine. The fill engine borrows port 2, stalling
//               host traffic there via s2_waitrequest; port 1 always has
//               priority over both port 2 and the engine on write collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module char_mem_dp_fill #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 13,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    // port 1
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    // port 2
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest,
    // fill engine
    input  logic                  fill_start,
    input  logic [ADDR_W-1:0]     fill_base,
    input  logic [ADDR_W:0]       fill_len,
    input  logic [DATA_W-1:0]     fill_value,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] w_fill_addr_nxt;
    logic [ADDR_W:0]   r_fill_remain;
    logic [ADDR_W:0]   w_fill_remain_nxt;
    logic [DATA_W-1:0] r_fill_value;
    logic [DATA_W-1:0] w_fill_value_nxt;

    logic              w_run;
    logic              w_fill_wr;
    logic              w_s1_wr;
    logic              w_s1_rd;
    logic              w_s2_wr;
    logic              w_s2_rd;

    logic [DATA_W-1:0] r_s1_rd_data;
    logic              r_s1_rd_valid;
    logic [DATA_W-1:0] r_s2_rd_data;
    logic              r_s2_rd_valid;

    // reset_req acts as a global clock-enable inhibit
    assign w_run = ~reset_req;

    assign fill_busy      = (r_state == ST_FILL);
    assign fill_done      = (r_state == ST_DONE);
    assign s2_waitrequest = (r_state == ST_FILL);

    // Engine writes are suppressed in a reset cycle so an abort takes effect at once
    assign w_fill_wr = (r_state == ST_FILL) & ~reset;
    assign w_s1_wr   = s1_chipselect & s1_write;
    assign w_s1_rd   = s1_chipselect & ~s1_write;
    assign w_s2_wr   = s2_chipselect & s2_write & ~s2_waitrequest;
    assign w_s2_rd   = s2_chipselect & ~s2_write & ~s2_waitrequest;

    // Fill FSM state and working registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fill_addr   <= '0;
            r_fill_remain <= '0;
            r_fill_value  <= '0;
        end else if (w_run) begin
            r_state       <= w_state_nxt;
            r_fill_addr   <= w_fill_addr_nxt;
            r_fill_remain <= w_fill_remain_nxt;
            r_fill_value  <= w_fill_value_nxt;
        end
    end

    // Fill FSM next-state: capture request in IDLE, one word per cycle in FILL
    always_comb begin
        w_state_nxt       = r_state;
        w_fill_addr_nxt   = r_fill_addr;
        w_fill_remain_nxt = r_fill_remain;
        w_fill_value_nxt  = r_fill_value;
        case (r_state)
            ST_IDLE: begin
                if (fill_start) begin
                    w_fill_addr_nxt   = fill_base;
                    w_fill_remain_nxt = fill_len;
                    w_fill_value_nxt  = fill_value;
                    w_state_nxt       = (fill_len == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                // ADDR_W-bit address wraps naturally modulo the depth
                w_fill_addr_nxt   = r_fill_addr + 1'b1;
                w_fill_remain_nxt = r_fill_remain - 1'b1;
                if (r_fill_remain == (ADDR_W + 1)'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Array writes; later assignments win, so port 1 overrides engine and port 2
    always_ff @(posedge clk) begin
        if (w_run) begin
            if (w_fill_wr) begin
                r_mem[r_fill_addr] <= r_fill_value;
            end
            for (int b = 0; b < LANES; b++) begin
                if (w_s2_wr && s2_byteenable[b]) begin
                    r_mem[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
                end
            end
            for (int b = 0; b < LANES; b++) begin
                if (w_s1_wr && s1_byteenable[b]) begin
                    r_mem[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
                end
            end
        end
    end

    // First read stage: array lookup returns pre-write contents; data held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_rd_data  <= '0;
            r_s1_rd_valid <= 1'b0;
            r_s2_rd_data  <= '0;
            r_s2_rd_valid <= 1'b0;
        end else if (w_run) begin
            r_s1_rd_valid <= w_s1_rd;
            r_s2_rd_valid <= w_s2_rd;
            if (w_s1_rd) begin
                r_s1_rd_data <= r_mem[s1_address];
            end
            if (w_s2_rd) begin
                r_s2_rd_data <= r_mem[s2_address];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_s1_out_data;
            logic              r_s1_out_valid;
            logic [DATA_W-1:0] r_s2_out_data;
            logic              r_s2_out_valid;

            // Optional output stage: forwards each completed read one cycle later
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_out_data  <= '0;
                    r_s1_out_valid <= 1'b0;
                    r_s2_out_data  <= '0;
                    r_s2_out_valid <= 1'b0;
                end else if (w_run) begin
                    r_s1_out_valid <= r_s1_rd_valid;
                    r_s2_out_valid <= r_s2_rd_valid;
                    if (r_s1_rd_valid) begin
                        r_s1_out_data <= r_s1_rd_data;
                    end
                    if (r_s2_rd_valid) begin
                        r_s2_out_data <= r_s2_rd_data;
                    end
                end
            end

            assign s1_readdata      = r_s1_out_data;
            assign s1_readdatavalid = r_s1_out_valid;
            assign s2_readdata      = r_s2_out_data;
            assign s2_readdatavalid = r_s2_out_valid;
        end else begin : g_no_out_reg
            assign s1_readdata      = r_s1_rd_data;
            assign s1_readdatavalid = r_s1_rd_valid;
            assign s2_readdata      = r_s2_rd_data;
            assign s2_readdatavalid = r_s2_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_char_mem_dp_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_mem_dp_fill
// Description : Scoreboard bench for char_mem_dp_fill with a flat-array model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_mem_dp_fill;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 13;
    localparam int OUT_REG = 0;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LAT     = 1 + OUT_REG;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [ADDR_W-1:0] s1_address;
    logic              s1_chipselect;
    logic              s1_write;
    logic [0:0]        s1_byteenable;
    logic [DATA_W-1:0] s1_writedata;
    logic [DATA_W-1:0] s1_readdata;
    logic              s1_readdatavalid;
    logic [ADDR_W-1:0] s2_address;
    logic              s2_chipselect;
    logic              s2_write;
    logic [0:0]        s2_byteenable;
    logic [DATA_W-1:0] s2_writedata;
    logic [DATA_W-1:0] s2_readdata;
    logic              s2_readdatavalid;
    logic              s2_waitrequest;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;

    always #5 clk = ~clk;

    char_mem_dp_fill #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OUT_REG(OUT_REG)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reset_req       (reset_req),
        .s1_address      (s1_address),
        .s1_chipselect   (s1_chipselect),
        .s1_write        (s1_write),
        .s1_byteenable   (s1_byteenable),
        .s1_writedata    (s1_writedata),
        .s1_readdata     (s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .s2_address      (s2_address),
        .s2_chipselect   (s2_chipselect),
        .s2_write        (s2_write),
        .s2_byteenable   (s2_byteenable),
        .s2_writedata    (s2_writedata),
        .s2_readdata     (s2_readdata),
        .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest  (s2_waitrequest),
        .fill_start      (fill_start),
        .fill_base       (fill_base),
        .fill_len        (fill_len),
        .fill_value      (fill_value),
        .fill_busy       (fill_busy),
        .fill_done       (fill_done)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q1[$];
    exp_t              q2[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                busy_cnt = 0;
    int                done_cnt = 0;
    bit                mon_en = 1'b0;

    // free-running cycle index used for latency expectations
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard whenever a port presents read data
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (fill_busy) busy_cnt++;
            if (fill_done) done_cnt++;
            if (mon_en) begin
                if (s1_readdatavalid) begin
                    if (q1.size() == 0) begin
                        check("s1_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        check("s1_rd_data", 32'(s1_readdata), 32'(e.data));
                        check("s1_rd_latency", 32'(cyc), 32'(e.due));
                    end
                end else if (q1.size() > 0 && q1[0].due < cyc) begin
                    e = q1.pop_front();
                    check("s1_rd_missing", 32'd0, 32'd1);
                end
                if (s2_readdatavalid) begin
                    if (q2.size() == 0) begin
                        check("s2_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = q2.pop_front();
                        check("s2_rd_data", 32'(s2_readdata), 32'(e.data));
                        check("s2_rd_latency", 32'(cyc), 32'(e.due));
                    end
                end else if (q2.size() > 0 && q2[0].due < cyc) begin
                    e = q2.pop_front();
                    check("s2_rd_missing", 32'd0, 32'd1);
                end
            end
        end
    endtask

    // One host cycle on both ports: reads see old contents, then s2 write, then s1 write
    task automatic do_cycle(
        input logic c1, input logic w1, input logic [ADDR_W-1:0] a1,
        input logic [7:0] d1, input logic b1,
        input logic c2, input logic w2, input logic [ADDR_W-1:0] a2,
        input logic [7:0] d2, input logic b2);
        s1_chipselect = c1; s1_write = w1; s1_address = a1; s1_writedata = d1; s1_byteenable = b1;
        s2_chipselect = c2; s2_write = w2; s2_address = a2; s2_writedata = d2; s2_byteenable = b2;
        if (c1 && !w1) q1.push_back('{due: cyc + LAT, data: model[a1]});
        if (c2 && !w2 && !s2_waitrequest) q2.push_back('{due: cyc + LAT, data: model[a2]});
        if (c2 && w2 && b2 && !s2_waitrequest) model[a2] = d2;
        if (c1 && w1 && b1) model[a1] = d1;
        tick();
        s1_chipselect = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_write = 1'b0;
    endtask

    task automatic read_pair(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        do_cycle(1'b1, 1'b0, a1, 8'h00, 1'b0, 1'b1, 1'b0, a2, 8'h00, 1'b0);
    endtask

    task automatic start_fill(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                              input logic [7:0] val, input bit upd);
        fill_start = 1'b1; fill_base = base; fill_len = len; fill_value = val;
        if (upd) begin
            for (int i = 0; i < int'(len); i++) model[(int'(base) + i) % DEPTH] = val;
        end
        tick();
        fill_start = 1'b0;
    endtask

    task automatic wait_fill_end();
        int n = 0;
        while ((fill_busy || fill_done) && n < 10000) begin
            tick();
            n++;
        end
        check("fill_end_timeout", 32'(fill_busy | fill_done), 32'd0);
    endtask

    initial begin
        int bs, ds, n;
        logic [ADDR_W-1:0] ra, rb;
        reset = 1'b1; reset_req = 1'b0;
        s1_address = '0; s1_chipselect = 1'b0; s1_write = 1'b0; s1_byteenable = '0; s1_writedata = '0;
        s2_address = '0; s2_chipselect = 1'b0; s2_write = 1'b0; s2_byteenable = '0; s2_writedata = '0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("rst_s1_readdata", 32'(s1_readdata), 32'd0);
        check("rst_s2_readdata", 32'(s2_readdata), 32'd0);
        check("rst_s1_valid", 32'(s1_readdatavalid), 32'd0);
        check("rst_s2_valid", 32'(s2_readdatavalid), 32'd0);
        check("rst_busy", 32'(fill_busy), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        check("rst_waitreq", 32'(s2_waitrequest), 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // full-depth fill with wrap from a non-zero base; initialises the whole array
        bs = busy_cnt; ds = done_cnt;
        start_fill(13'h0123, 14'h2000, 8'hE1, 1'b1);
        wait_fill_end();
        check("full_fill_busy_cycles", 32'(busy_cnt - bs), 32'd8192);
        check("full_fill_done_pulses", 32'(done_cnt - ds), 32'd1);
        for (int i = 0; i < DEPTH / 2; i++) read_pair(ADDR_W'(i), ADDR_W'(i + DEPTH / 2));

        // s1 write then s2 read of the same word
        do_cycle(1'b1, 1'b1, 13'h0010, 8'hA5, 1'b1, 1'b0, 1'b0, 13'h0, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 13'h0010, 8'h00, 1'b0);

        // mixed-port read-during-write returns old data
        do_cycle(1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 13'h0100, 8'h22, 1'b1);
        do_cycle(1'b1, 1'b1, 13'h0100, 8'h11, 1'b1, 1'b1, 1'b0, 13'h0100, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 13'h0100, 8'h00, 1'b0);
        repeat (3) tick();
        check("s2_readdata_hold", 32'(s2_readdata), 32'h11);
        check("s2_valid_idle", 32'(s2_readdatavalid), 32'd0);

        // simultaneous writes: s1 wins; disabled s1 lane lets s2 through
        do_cycle(1'b1, 1'b1, 13'h0200, 8'h33, 1'b1, 1'b1, 1'b1, 13'h0200, 8'h44, 1'b1);
        do_cycle(1'b1, 1'b1, 13'h0201, 8'h55, 1'b0, 1'b1, 1'b1, 13'h0201, 8'h66, 1'b1);
        read_pair(13'h0200, 13'h0201);

        // randomized traffic over a small window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                     8'($urandom), 1'($urandom_range(0, 3) != 0),
                     $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                     8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 16; i++) read_pair(ADDR_W'(i), ADDR_W'(i + 16));

        // wrapping fill with port-1 collision, stalled port-2 write and ignored restart
        do_cycle(1'b1, 1'b1, 13'h0002, 8'h5A, 1'b1, 1'b0, 1'b0, 13'h0, 8'h00, 1'b0);
        bs = busy_cnt; ds = done_cnt;
        start_fill(13'h1FFE, 14'd4, 8'h20, 1'b1);
        check("waitreq_in_fill", 32'(s2_waitrequest), 32'd1);
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 13'h1FFE; s1_writedata = 8'h77; s1_byteenable = 1'b1;
        s2_chipselect = 1'b1; s2_write = 1'b1; s2_address = 13'h0005; s2_writedata = 8'h66; s2_byteenable = 1'b1;
        tick();
        s1_chipselect = 1'b0; s1_write = 1'b0;
        model[13'h1FFE] = 8'h77;
        fill_start = 1'b1; fill_base = 13'h0400; fill_len = 14'd2; fill_value = 8'hEE;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (s2_waitrequest && n < 50) begin
            tick();
            n++;
        end
        check("waitreq_released", 32'(s2_waitrequest), 32'd0);
        check("busy_at_release", 32'(fill_busy), 32'd0);
        check("done_at_release", 32'(fill_done), 32'd1);
        tick();
        s2_chipselect = 1'b0; s2_write = 1'b0;
        model[13'h0005] = 8'h66;
        wait_fill_end();
        check("fill4_busy_cycles", 32'(busy_cnt - bs), 32'd4);
        check("fill4_done_pulses", 32'(done_cnt - ds), 32'd1);
        for (int i = 0; i < 9; i++) begin
            ra = ADDR_W'(13'h1FFD + i);
            read_pair(ra, 13'h0400 + ADDR_W'(i % 2));
        end

        // reset_req freeze for three cycles mid-fill
        bs = busy_cnt; ds = done_cnt;
        start_fill(13'h0300, 14'd6, 8'h3C, 1'b1);
        repeat (2) tick();
        reset_req = 1'b1;
        repeat (3) tick();
        check("busy_frozen", 32'(fill_busy), 32'd1);
        reset_req = 1'b0;
        wait_fill_end();
        check("freeze_busy_cycles", 32'(busy_cnt - bs), 32'd9);
        check("freeze_done_pulses", 32'(done_cnt - ds), 32'd1);
        for (int i = 0; i < 4; i++) read_pair(13'h02FF + ADDR_W'(i), 13'h0303 + ADDR_W'(i));

        // reset mid-fill aborts; three words already written remain
        bs = busy_cnt; ds = done_cnt;
        start_fill(13'h0500, 14'd10, 8'h99, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) model[13'h0500 + i] = 8'h99;
        check("abort_busy", 32'(fill_busy), 32'd0);
        check("abort_waitreq", 32'(s2_waitrequest), 32'd0);
        tick();
        check("abort_no_done", 32'(done_cnt - ds), 32'd0);
        check("abort_busy_cycles", 32'(busy_cnt - bs), 32'd4);
        for (int i = 0; i < 3; i++) read_pair(13'h04FF + ADDR_W'(i), 13'h0502 + ADDR_W'(i));

        // zero-length fill: done pulse next cycle, nothing written
        bs = busy_cnt; ds = done_cnt;
        start_fill(13'h0600, 14'd0, 8'hC3, 1'b1);
        check("len0_done", 32'(fill_done), 32'd1);
        check("len0_busy", 32'(fill_busy), 32'd0);
        tick();
        check("len0_done_low", 32'(fill_done), 32'd0);
        check("len0_done_pulses", 32'(done_cnt - ds), 32'd1);
        check("len0_busy_cycles", 32'(busy_cnt - bs), 32'd0);
        rb = 13'h0600;
        read_pair(rb, rb + 1'b1);

        repeat (4) tick();
        check("s1_queue_drained", 32'(q1.size()), 32'd0);
        check("s2_queue_drained", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
